// File: rtl/qm_alu_mc_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the qm multi-cycle ALU.
package qm_alu_mc_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND  = 4'd0;
  localparam alu_op_t ALU_OR   = 4'd1;
  localparam alu_op_t ALU_ADD  = 4'd2;
  localparam alu_op_t ALU_XOR  = 4'd3;
  localparam alu_op_t ALU_SLL  = 4'd4;
  localparam alu_op_t ALU_SRL  = 4'd5;
  localparam alu_op_t ALU_SUB  = 4'd6;
  localparam alu_op_t ALU_SLT  = 4'd7;
  localparam alu_op_t ALU_SRA  = 4'd8;
  localparam alu_op_t ALU_SLTU = 4'd9;
  localparam alu_op_t ALU_MUL  = 4'd10;
  localparam alu_op_t ALU_MULU = 4'd11;
  localparam alu_op_t ALU_NOR  = 4'd12;
  localparam alu_op_t ALU_DIV  = 4'd13;
  localparam alu_op_t ALU_DIVU = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input alu_op_t op);
    return op inside {ALU_MUL, ALU_MULU, ALU_DIV, ALU_DIVU};
  endfunction

  function automatic logic is_div(input alu_op_t op);
    return op inside {ALU_DIV, ALU_DIVU};
  endfunction

  function automatic logic is_signed_md(input alu_op_t op);
    return op inside {ALU_MUL, ALU_DIV};
  endfunction

endpackage

// File: rtl/qm_alu_muldiv.sv
// Iterative unsigned W x W shift-add multiplier / W / W restoring divider, one step per cycle.
// Multiply leaves {hi,lo} = product; divide leaves lo = quotient, hi = remainder.
module qm_alu_muldiv #(
  parameter  int W  = 32,
  localparam int CW = $clog2(W) + 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         i_start,
  input  logic         i_div,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  logic [W-1:0]  r_hi, r_lo, r_b;
  logic          r_div;
  logic [CW-1:0] r_cnt;
  logic [W:0]    w_mul_sum, w_div_shift, w_div_diff;

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_div_shift = {r_hi, r_lo[W-1]};
    w_div_diff  = w_div_shift - {1'b0, r_b};
  end

  // NOTE: state uses non-blocking '<=' and a synchronous active-high reset sampled on the clock edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_div <= i_div;
      r_cnt <= CW'(W);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_div) begin
        // A clear borrow bit means the shifted partial remainder covers the divisor.
        if (!w_div_diff[W]) begin
          r_hi <= w_div_diff[W-1:0];
          r_lo <= {r_lo[W-2:0], 1'b1};
        end else begin
          r_hi <= w_div_shift[W-1:0];
          r_lo <= {r_lo[W-2:0], 1'b0};
        end
      end else begin
        {r_hi, r_lo} <= {w_mul_sum, r_lo[W-1:1]};
      end
    end
  end

  assign o_done = (r_cnt == CW'(1));
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/qm_alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle ops plus iterative mul/div behind a valid/ready handshake.
// Optional macro QM_ALU_OVERFLOW_TRAP_EN adds o_Overflow for signed ADD/SUB overflow.
module qm_alu_mc
  import qm_alu_mc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [3:0]   i_ALUControl,
  input  logic [W-1:0] i_A,
  input  logic [W-1:0] i_B,
  output logic         o_Valid,
  output logic [W-1:0] o_Result,
`ifdef QM_ALU_OVERFLOW_TRAP_EN
  output logic         o_Overflow,
`endif
  output logic [W-1:0] o_Hi
);

  localparam int SW = $clog2(W);

  state_e         r_state, w_next_state;
  logic           w_start_md, w_fix, w_accept_sc;
  logic           r_valid, r_md_div, r_neg_q, r_neg_r, r_div_zero;
  logic [W-1:0]   r_result, r_hi;
  logic [W-1:0]   w_sc_result, w_sum, w_diff, w_abs_a, w_abs_b;
  logic [SW-1:0]  w_shamt;
  logic           w_sgn_op, w_sa, w_sb;
  logic           w_core_done;
  logic [W-1:0]   w_core_hi, w_core_lo, w_fix_q, w_fix_r;
  logic [2*W-1:0] w_fix_prod;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_Ready      = 1'b0;
    w_start_md   = 1'b0;
    w_fix        = 1'b0;
    w_accept_sc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_Ready = 1'b1;
        if (i_Valid) begin
          if (is_muldiv(i_ALUControl)) begin
            w_start_md   = 1'b1;
            w_next_state = ST_ITER;
          end else begin
            w_accept_sc  = 1'b1;
          end
        end
      end
      ST_ITER: if (w_core_done) w_next_state = ST_FIX;
      ST_FIX: begin
        w_fix        = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_shamt = i_B[SW-1:0];
    w_sum   = i_A + i_B;
    w_diff  = i_A - i_B;
    case (i_ALUControl)
      ALU_AND:  w_sc_result = i_A & i_B;
      ALU_OR:   w_sc_result = i_A | i_B;
      ALU_XOR:  w_sc_result = i_A ^ i_B;
      ALU_NOR:  w_sc_result = ~(i_A | i_B);
      ALU_ADD:  w_sc_result = w_sum;
      ALU_SUB:  w_sc_result = w_diff;
      ALU_SLL:  w_sc_result = i_A << w_shamt;
      ALU_SRL:  w_sc_result = i_A >> w_shamt;
      ALU_SRA:  w_sc_result = $unsigned($signed(i_A) >>> w_shamt);
      ALU_SLT:  w_sc_result = {{(W-1){1'b0}}, $signed(i_A) < $signed(i_B)};
      ALU_SLTU: w_sc_result = {{(W-1){1'b0}}, i_A < i_B};
      default:  w_sc_result = '0;
    endcase
  end

  // Signed mul/div runs on magnitudes; signs are recorded at accept and applied in FIX.
  always_comb begin
    w_sgn_op = is_signed_md(i_ALUControl);
    w_sa     = w_sgn_op && i_A[W-1];
    w_sb     = w_sgn_op && i_B[W-1];
    w_abs_a  = w_sa ? -i_A : i_A;
    w_abs_b  = w_sb ? -i_B : i_B;
  end

  qm_alu_muldiv #(.W(W)) u_muldiv (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .i_start (w_start_md),
    .i_div   (is_div(i_ALUControl)),
    .i_a     (w_abs_a),
    .i_b     (w_abs_b),
    .o_done  (w_core_done),
    .o_hi    (w_core_hi),
    .o_lo    (w_core_lo)
  );

  // Divide by zero keeps the all-ones quotient regardless of operand signs.
  always_comb begin
    w_fix_prod = r_neg_q ? -{w_core_hi, w_core_lo} : {w_core_hi, w_core_lo};
    w_fix_q    = (r_neg_q && !r_div_zero) ? -w_core_lo : w_core_lo;
    w_fix_r    = r_neg_r ? -w_core_hi : w_core_hi;
  end

`ifdef QM_ALU_OVERFLOW_TRAP_EN
  logic r_ovf, w_sc_ovf;

  always_comb begin
    w_sc_ovf = 1'b0;
    if (i_ALUControl == ALU_ADD)
      w_sc_ovf = (i_A[W-1] == i_B[W-1]) && (w_sum[W-1] != i_A[W-1]);
    else if (i_ALUControl == ALU_SUB)
      w_sc_ovf = (i_A[W-1] != i_B[W-1]) && (w_diff[W-1] != i_A[W-1]);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)          r_ovf <= 1'b0;
    else if (w_accept_sc) r_ovf <= w_sc_ovf;
    else if (w_fix)       r_ovf <= 1'b0;
  end

  assign o_Overflow = r_ovf & r_valid;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_hi       <= '0;
      r_md_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept_sc) begin
        r_result <= w_sc_result;
        r_hi     <= '0;
        r_valid  <= 1'b1;
      end else if (w_start_md) begin
        r_md_div   <= is_div(i_ALUControl);
        r_neg_q    <= w_sa ^ w_sb;
        r_neg_r    <= is_div(i_ALUControl) && w_sa;
        r_div_zero <= is_div(i_ALUControl) && (i_B == '0);
      end else if (w_fix) begin
        if (r_md_div) begin
          r_result <= w_fix_q;
          r_hi     <= w_fix_r;
        end else begin
          {r_hi, r_result} <= w_fix_prod;
        end
        r_valid <= 1'b1;
      end
    end
  end

  assign o_Valid  = r_valid;
  assign o_Result = r_result;
  assign o_Hi     = r_hi;

endmodule

// File: tb/tb_qm_alu_mc.sv
// Directed self-checking bench for qm_alu_mc: W=32 instance for all ops plus a W=8 multiply instance.
module tb_qm_alu_mc;
  import qm_alu_mc_pkg::*;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [3:0]    i_op    = ALU_AND;
  logic [W-1:0]  i_a     = '0;
  logic [W-1:0]  i_b     = '0;
  logic          o_ready, o_valid;
  logic [W-1:0]  o_result, o_hi;

  logic          i8_valid = 1'b0;
  logic [3:0]    i8_op    = ALU_AND;
  logic [W8-1:0] i8_a     = '0;
  logic [W8-1:0] i8_b     = '0;
  logic          o8_ready, o8_valid;
  logic [W8-1:0] o8_result, o8_hi;

`ifdef QM_ALU_OVERFLOW_TRAP_EN
  logic o_ovf, o8_ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  qm_alu_mc #(.W(W)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .i_Valid      (i_valid),
    .o_Ready      (o_ready),
    .i_ALUControl (i_op),
    .i_A          (i_a),
    .i_B          (i_b),
    .o_Valid      (o_valid),
    .o_Result     (o_result),
`ifdef QM_ALU_OVERFLOW_TRAP_EN
    .o_Overflow   (o_ovf),
`endif
    .o_Hi         (o_hi)
  );

  qm_alu_mc #(.W(W8)) dut8 (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .i_Valid      (i8_valid),
    .o_Ready      (o8_ready),
    .i_ALUControl (i8_op),
    .i_A          (i8_a),
    .i_B          (i8_b),
    .o_Valid      (o8_valid),
    .o_Result     (o8_result),
`ifdef QM_ALU_OVERFLOW_TRAP_EN
    .o_Overflow   (o8_ovf),
`endif
    .o_Hi         (o8_hi)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Drives one request for a single edge; outputs are then observed in cycle 1.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic check_sc(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
    issue(op, a, b);
    check({tag, "_valid"}, W'(o_valid), W'(1));
    check({tag, "_result"}, o_result, exp);
    check({tag, "_hi"}, o_hi, '0);
  endtask

  // Issues a mul/div, scrambles inputs while busy, and expects the result exactly in cycle W+2.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
    int busy_bad;
    busy_bad = 0;
    issue(op, a, b);
    for (int c = 1; c <= W + 1; c++) begin
      if (o_ready !== 1'b0 || o_valid !== 1'b0) busy_bad++;
      i_valid = c[0] && (c < W + 1);
      i_op    = c[1] ? ALU_ADD : ALU_DIVU;
      i_a     = $urandom;
      i_b     = $urandom;
      tick();
    end
    i_valid = 1'b0;
    check({tag, "_busy_cycles"}, W'(busy_bad), '0);
    check({tag, "_valid"}, W'(o_valid), W'(1));
    check({tag, "_ready"}, W'(o_ready), W'(1));
    check({tag, "_lo"}, o_result, exp_lo);
    check({tag, "_hi"}, o_hi, exp_hi);
`ifdef QM_ALU_OVERFLOW_TRAP_EN
    check({tag, "_ovf"}, W'(o_ovf), '0);
`endif
    tick();
    check({tag, "_valid_drop"}, W'(o_valid), '0);
  endtask

  initial begin
    int seen;
    int late_valid;
    logic [W8-1:0] got8_hi, got8_lo;

    tick();
    tick();
    sys_rst = 1'b0;
    check("rst_ready", W'(o_ready), W'(1));
    check("rst_valid", W'(o_valid), '0);
    check("rst_result", o_result, '0);
    check("rst_hi", o_hi, '0);

    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    check("add_valid", W'(o_valid), W'(1));
    check("add_ready", W'(o_ready), W'(1));
    check("add_result", o_result, 32'h8000_0000);
`ifdef QM_ALU_OVERFLOW_TRAP_EN
    check("add_ovf", W'(o_ovf), W'(1));
`endif
    issue(ALU_SUB, 32'h0, 32'h1);
    check("sub_valid", W'(o_valid), W'(1));
    check("sub_ready", W'(o_ready), W'(1));
    check("sub_result", o_result, 32'hFFFF_FFFF);
`ifdef QM_ALU_OVERFLOW_TRAP_EN
    check("sub_ovf", W'(o_ovf), '0);
`endif
    tick();
    check("idle_valid", W'(o_valid), '0);
    check("idle_hold", o_result, 32'hFFFF_FFFF);

    check_sc("sub_wrap", ALU_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF);
`ifdef QM_ALU_OVERFLOW_TRAP_EN
    check("sub_wrap_ovf", W'(o_ovf), W'(1));
`endif
    check_sc("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    check_sc("srl_trunc", ALU_SRL, 32'h8000_0000, 32'd36, 32'h0800_0000);
    check_sc("sll", ALU_SLL, 32'h1, 32'd31, 32'h8000_0000);
    check_sc("slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1);
    check_sc("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0);
    check_sc("nor", ALU_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF);
    check_sc("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    check_sc("or", ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    check_sc("xor", ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5);
    check_sc("undef_op", 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);

    run_md("mul", ALU_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    run_md("mulu", ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
    run_md("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_md("divu_zero", ALU_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7);
    run_md("div_zero", ALU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run_md("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    run_md("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);

    issue(ALU_DIVU, 32'd1000, 32'd3);
    repeat (9) tick();
    sys_rst = 1'b1;
    tick();
    check("abort_ready", W'(o_ready), W'(1));
    check("abort_valid", W'(o_valid), '0);
    check("abort_result", o_result, '0);
    check("abort_hi", o_hi, '0);
    sys_rst = 1'b0;
    late_valid = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_valid !== 1'b0) late_valid++;
      tick();
    end
    check("abort_no_late_valid", W'(late_valid), '0);
    check_sc("post_abort_add", ALU_ADD, 32'd2, 32'd3, 32'd5);

    i8_valid = 1'b1;
    i8_op    = ALU_MULU;
    i8_a     = 8'hFF;
    i8_b     = 8'hFF;
    tick();
    i8_valid = 1'b0;
    seen     = 0;
    got8_hi  = '0;
    got8_lo  = '0;
    for (int c = 1; c <= 20; c++) begin
      if (o8_valid === 1'b1 && seen == 0) begin
        seen    = c;
        got8_hi = o8_hi;
        got8_lo = o8_result;
      end
      tick();
    end
    check("w8_mulu_cycle", W'(seen), W'(10));
    check("w8_mulu_hi", W'(got8_hi), W'(8'hFE));
    check("w8_mulu_lo", W'(got8_lo), W'(8'h01));
    check("w8_ready", W'(o8_ready), W'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
